// File: rtl/ws2812_pkg.sv
// Shared WS2812 receive definitions: timing derived from the clock frequency,
// the decoder state encoding and the error cause codes.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        LOW      = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    localparam logic [1:0] ERR_GLITCH   = 2'd0;
    localparam logic [1:0] ERR_STUCK    = 2'd1;
    localparam logic [1:0] ERR_PARTIAL  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    function automatic int phase_cycles(input int clock_frequency);
        return clock_frequency / 2380000 + 1;
    endfunction

    function automatic int t_min(input int clock_frequency);
        return phase_cycles(clock_frequency) / 2;
    endfunction

    function automatic int t_one(input int clock_frequency);
        return phase_cycles(clock_frequency) + phase_cycles(clock_frequency) / 2;
    endfunction

    function automatic int t_max(input int clock_frequency);
        return 3 * phase_cycles(clock_frequency);
    endfunction

    function automatic int t_rst(input int clock_frequency, input int reset_phases);
        return reset_phases * phase_cycles(clock_frequency);
    endfunction

endpackage

// File: rtl/ws2812_rx_decoder_pulse_meter.sv
// Synchronises the WS2812 line, detects edges and measures high/low times.
// With WS2812_RX_FWD_EN the synchronised line is also exported for forwarding.
module ws2812_pulse_meter
    import ws2812_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 38000000,
    parameter int RESET_PHASES    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic bit_valid,
    output logic bit_value,
    output logic glitch,
    output logic stuck_high,
    output logic gap_reached
`ifdef WS2812_RX_FWD_EN
    ,
    output logic line
`endif
);

    localparam logic [15:0] T_MIN_C = 16'(t_min(CLOCK_FREQUENCY));
    localparam logic [15:0] T_ONE_C = 16'(t_one(CLOCK_FREQUENCY));
    localparam logic [15:0] T_MAX_C = 16'(t_max(CLOCK_FREQUENCY));
    localparam logic [15:0] T_RST_C = 16'(t_rst(CLOCK_FREQUENCY, RESET_PHASES));

    logic        sync_a_r;
    logic        sync_b_r;
    logic        line_r;
    logic [15:0] hi_cnt_r;
    logic [15:0] lo_cnt_r;
    logic        rise_s;
    logic        fall_s;

    assign rise_s = sync_b_r & ~line_r;
    assign fall_s = ~sync_b_r & line_r;

    // two-flop synchroniser followed by the edge-detect register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a_r <= 1'b0;
            sync_b_r <= 1'b0;
            line_r   <= 1'b0;
        end else begin
            sync_a_r <= din;
            sync_b_r <= sync_a_r;
            line_r   <= sync_b_r;
        end
    end

    // saturating high/low time counters, each cleared by the opposite edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_r <= 16'd0;
            lo_cnt_r <= 16'd0;
        end else begin
            if (fall_s) begin
                hi_cnt_r <= 16'd0;
            end else if (sync_b_r && hi_cnt_r != 16'hFFFF) begin
                hi_cnt_r <= hi_cnt_r + 16'd1;
            end else begin
                hi_cnt_r <= hi_cnt_r;
            end
            if (rise_s) begin
                lo_cnt_r <= 16'd0;
            end else if (!sync_b_r && lo_cnt_r != 16'hFFFF) begin
                lo_cnt_r <= lo_cnt_r + 16'd1;
            end else begin
                lo_cnt_r <= lo_cnt_r;
            end
        end
    end

    assign rise        = rise_s;
    assign bit_valid   = fall_s && (hi_cnt_r >= T_MIN_C);
    assign glitch      = fall_s && (hi_cnt_r < T_MIN_C);
    assign bit_value   = (hi_cnt_r >= T_ONE_C);
    assign stuck_high  = sync_b_r && (hi_cnt_r > T_MAX_C);
    assign gap_reached = !sync_b_r && (lo_cnt_r == T_RST_C);

`ifdef WS2812_RX_FWD_EN
    assign line = sync_b_r;
`endif

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 line decoder: recovers 24-bit colour words with their LED index onto a
// valid/ready stream. Optional WS2812_RX_FWD_EN adds dout_o daisy-chain forwarding.
module ws2812_rx_decoder
    import ws2812_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 38000000,
    parameter int LED_COUNT       = 3,
    parameter int RESET_PHASES    = 8
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        din_i,
    output logic [23:0] data_o,
    output logic [7:0]  index_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
`ifdef WS2812_RX_FWD_EN
    ,
    output logic        dout_o
`endif
);

    localparam logic [7:0] LED_LIMIT = 8'(LED_COUNT);

    state_t      state_r, next_state_s;
    logic [23:0] shift_r, shift_s;
    logic [4:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  word_idx_r, word_idx_s;
    logic [23:0] data_r, data_s;
    logic [7:0]  index_r, index_s;
    logic        valid_r, valid_s;
    logic        frame_done_r, frame_done_s;
    logic        err_r, err_s;
    logic [1:0]  err_code_r, err_code_s;
    logic        rise_s, bit_valid_s, bit_value_s, glitch_s, stuck_high_s, gap_reached_s;

`ifdef WS2812_RX_FWD_EN
    logic line_s;
    logic dout_r;
`endif

    ws2812_pulse_meter #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
        .RESET_PHASES   (RESET_PHASES)
    ) u_meter (
        .clk        (clk_i),
        .rst_n      (resetn_i),
        .din        (din_i),
        .rise       (rise_s),
        .bit_valid  (bit_valid_s),
        .bit_value  (bit_value_s),
        .glitch     (glitch_s),
        .stuck_high (stuck_high_s),
        .gap_reached(gap_reached_s)
`ifdef WS2812_RX_FWD_EN
        ,
        .line       (line_s)
`endif
    );

    // next-state, word assembly, stream and error decisions
    always_comb begin
        next_state_s = state_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        word_idx_s   = word_idx_r;
        data_s       = data_r;
        index_s      = index_r;
        valid_s      = valid_r && !ready_i;
        frame_done_s = 1'b0;
        err_s        = 1'b0;
        err_code_s   = err_code_r;
        case (state_r)
            IDLE: begin
                next_state_s = rise_s ? HIGH : IDLE;
            end
            HIGH: begin
                if (stuck_high_s) begin
                    err_s        = 1'b1;
                    err_code_s   = ERR_STUCK;
                    bit_cnt_s    = 5'd0;
                    next_state_s = WAIT_LOW;
                end else if (glitch_s) begin
                    err_s        = 1'b1;
                    err_code_s   = ERR_GLITCH;
                    next_state_s = LOW;
                end else if (bit_valid_s) begin
                    shift_s      = {shift_r[22:0], bit_value_s};
                    next_state_s = LOW;
                    if (bit_cnt_r == 5'd23) begin
                        bit_cnt_s  = 5'd0;
                        word_idx_s = (word_idx_r == 8'hFF) ? word_idx_r : word_idx_r + 8'd1;
                        // words past this decoder's LEDs belong further down the chain
                        if (word_idx_r >= LED_LIMIT) begin
                            valid_s = valid_r && !ready_i;
                        end else if (!valid_r || ready_i) begin
                            data_s  = shift_s;
                            index_s = word_idx_r;
                            valid_s = 1'b1;
                        end else begin
                            err_s      = 1'b1;
                            err_code_s = ERR_OVERFLOW;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end
                end else begin
                    next_state_s = HIGH;
                end
            end
            LOW: begin
                if (rise_s) begin
                    next_state_s = HIGH;
                end else if (gap_reached_s) begin
                    err_s        = (bit_cnt_r != 5'd0);
                    err_code_s   = (bit_cnt_r != 5'd0) ? ERR_PARTIAL : err_code_r;
                    frame_done_s = 1'b1;
                    word_idx_s   = 8'd0;
                    bit_cnt_s    = 5'd0;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOW;
                end
            end
            WAIT_LOW: begin
                if (gap_reached_s) begin
                    word_idx_s   = 8'd0;
                    bit_cnt_s    = 5'd0;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_LOW;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r      <= IDLE;
            shift_r      <= 24'd0;
            bit_cnt_r    <= 5'd0;
            word_idx_r   <= 8'd0;
            data_r       <= 24'd0;
            index_r      <= 8'd0;
            valid_r      <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= 2'd0;
        end else begin
            state_r      <= next_state_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            word_idx_r   <= word_idx_s;
            data_r       <= data_s;
            index_r      <= index_s;
            valid_r      <= valid_s;
            frame_done_r <= frame_done_s;
            err_r        <= err_s;
            err_code_r   <= err_code_s;
        end
    end

`ifdef WS2812_RX_FWD_EN
    // pass the line downstream once this decoder's own LEDs have been served
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            dout_r <= 1'b0;
        end else begin
            dout_r <= (word_idx_r >= LED_LIMIT) ? line_s : 1'b0;
        end
    end

    assign dout_o = dout_r;
`endif

    assign data_o       = data_r;
    assign index_o      = index_r;
    assign valid_o      = valid_r;
    assign frame_done_o = frame_done_r;
    assign err_o        = err_r;
    assign err_code_o   = err_code_r;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder at 38 MHz, LED_COUNT=3 (phase = 16 cycles).
module tb_ws2812_rx_decoder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        din = 1'b0;
    logic        ready = 1'b1;
    logic [23:0] data;
    logic [7:0]  index;
    logic        valid;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_code;
`ifdef WS2812_RX_FWD_EN
    logic        dout;
`endif

    ws2812_rx_decoder #(
        .CLOCK_FREQUENCY(38000000),
        .LED_COUNT      (3),
        .RESET_PHASES   (8)
    ) dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .din_i       (din),
        .data_o      (data),
        .index_o     (index),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_done_o(frame_done),
        .err_o       (err),
        .err_code_o  (err_code)
`ifdef WS2812_RX_FWD_EN
        ,
        .dout_o      (dout)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // event recorder, sampled on the falling edge
    logic [23:0] cap_data [64];
    logic [7:0]  cap_idx  [64];
    int          cap_n = 0;
    logic [1:0]  err_codes [64];
    int          err_cyc   [64];
    int          err_n = 0;
    int          fd_n = 0;
    int          fd_cyc = 0;

    always @(negedge clk) begin
        if (valid && ready && cap_n < 64) begin
            cap_data[cap_n] <= data;
            cap_idx[cap_n]  <= index;
            cap_n           <= cap_n + 1;
        end
        if (err && err_n < 64) begin
            err_codes[err_n] <= err_code;
            err_cyc[err_n]   <= cyc;
            err_n            <= err_n + 1;
        end
        if (frame_done) begin
            fd_n   <= fd_n + 1;
            fd_cyc <= cyc;
        end
    end

`ifdef WS2812_RX_FWD_EN
    int       fwd_mode = 0;
    int       fwd_n = 0;
    int       fwd_bad = 0;
    logic [2:0] din_hist = 3'b000;

    always @(negedge clk) begin
        din_hist <= {din_hist[1:0], din};
        if (fwd_mode == 1) begin
            fwd_n <= fwd_n + 1;
            if (dout !== 1'b0) fwd_bad <= fwd_bad + 1;
        end else if (fwd_mode == 2) begin
            fwd_n <= fwd_n + 1;
            if (dout !== din_hist[2]) fwd_bad <= fwd_bad + 1;
        end
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        drive(1'b1, b ? 32 : 16);
        drive(1'b0, b ? 16 : 32);
    endtask

    task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(w, 23, 0);
    endtask

    typedef struct packed {
        logic [23:0] word;
        logic [23:0] exp_data;
        logic [7:0]  exp_idx;
        logic        end_frame;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int c0, e0, f0, t0;
        vecs[0] = '{24'hFF0000, 24'hFF0000, 8'd0, 1'b0};
        vecs[1] = '{24'h00A5C3, 24'h00A5C3, 8'd1, 1'b0};
        vecs[2] = '{24'h000001, 24'h000001, 8'd2, 1'b1};
        vecs[3] = '{24'h123456, 24'h123456, 8'd0, 1'b0};
        vecs[4] = '{24'hABCDEF, 24'hABCDEF, 8'd1, 1'b0};
        vecs[5] = '{24'h800001, 24'h800001, 8'd2, 1'b1};

        repeat (4) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        resetn = 1'b1;
        drive(1'b0, 10);

        // loopback frames with ready held high
        e0 = err_n;
        for (int i = 0; i < 6; i++) begin
            c0 = cap_n;
            send_word(vecs[i].word);
            check("loop_count", 32'(cap_n - c0), 32'd1);
            check("loop_data", 32'(cap_data[c0]), 32'(vecs[i].exp_data));
            check("loop_index", 32'(cap_idx[c0]), 32'(vecs[i].exp_idx));
            if (vecs[i].end_frame) begin
                f0 = fd_n;
                send_bits(24'h0, -1, 0);
                drive(1'b0, 130);
                check("loop_frame_done", 32'(fd_n - f0), 32'd1);
            end
        end
        check("loop_no_err", 32'(err_n - e0), 32'd0);

        // back-pressure: first word held, later words overflow
        ready = 1'b0;
        e0 = err_n; c0 = cap_n; f0 = fd_n;
        send_word(24'hFF0000);
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_data_first", 32'(data), 32'hFF0000);
        send_word(24'h00A5C3);
        send_word(24'h000001);
        check("bp_hold_data", 32'(data), 32'hFF0000);
        check("bp_hold_index", 32'(index), 32'd0);
        check("bp_hold_valid", 32'(valid), 32'd1);
        check("bp_overflow_cnt", 32'(err_n - e0), 32'd2);
        check("bp_overflow_code0", 32'(err_codes[e0]), 32'd3);
        check("bp_overflow_code1", 32'(err_codes[e0 + 1]), 32'd3);
        drive(1'b0, 130);
        check("bp_frame_done", 32'(fd_n - f0), 32'd1);
        check("bp_none_taken", 32'(cap_n - c0), 32'd0);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        drive(1'b0, 4);
        check("bp_accept_once", 32'(cap_n - c0), 32'd1);
        check("bp_accept_data", 32'(cap_data[c0]), 32'hFF0000);
        check("bp_accept_index", 32'(cap_idx[c0]), 32'd0);
        check("bp_drained", 32'(valid), 32'd0);
        check("bp_code_sticky", 32'(err_code), 32'd3);
        ready = 1'b1;

        // glitch pulse inside a word
        e0 = err_n; c0 = cap_n; f0 = fd_n;
        send_bits(24'h00A5C3, 23, 12);
        drive(1'b1, 5);
        drive(1'b0, 20);
        send_bits(24'h00A5C3, 11, 0);
        check("glitch_err_cnt", 32'(err_n - e0), 32'd1);
        check("glitch_code", 32'(err_codes[e0]), 32'd0);
        check("glitch_word_cnt", 32'(cap_n - c0), 32'd1);
        check("glitch_word_data", 32'(cap_data[c0]), 32'h00A5C3);
        drive(1'b0, 130);
        check("glitch_frame_done", 32'(fd_n - f0), 32'd1);
        check("glitch_no_partial", 32'(err_n - e0), 32'd1);

        // stuck-high, then a clean frame
        e0 = err_n; c0 = cap_n; f0 = fd_n; t0 = cyc;
        drive(1'b1, 100);
        drive(1'b0, 140);
        check("stuck_err_cnt", 32'(err_n - e0), 32'd1);
        check("stuck_code", 32'(err_codes[e0]), 32'd1);
        check("stuck_time", 32'(err_cyc[e0] - t0), 32'd52);
        check("stuck_no_frame_done", 32'(fd_n - f0), 32'd0);
        send_word(24'h5A5A5A);
        drive(1'b0, 130);
        check("stuck_next_data", 32'(cap_data[c0]), 32'h5A5A5A);
        check("stuck_next_index", 32'(cap_idx[c0]), 32'd0);
        check("stuck_next_frame_done", 32'(fd_n - f0), 32'd1);

        // partial frame of 12 bits
        e0 = err_n; c0 = cap_n; f0 = fd_n;
        send_bits(24'hABCDEF, 23, 12);
        drive(1'b0, 128);
        check("partial_err_cnt", 32'(err_n - e0), 32'd1);
        check("partial_code", 32'(err_codes[e0]), 32'd2);
        check("partial_frame_done", 32'(fd_n - f0), 32'd1);
        check("partial_same_cycle", 32'(fd_cyc), 32'(err_cyc[e0]));
        check("partial_no_valid", 32'(cap_n - c0), 32'd0);

`ifdef WS2812_RX_FWD_EN
        // forwarding of the word beyond LED_COUNT
        c0 = cap_n;
        fwd_mode = 1;
        send_word(24'h111111);
        send_word(24'h222222);
        send_word(24'h333333);
        fwd_mode = 2;
        send_word(24'hC3A5F0);
        fwd_mode = 1;
        drive(1'b0, 130);
        fwd_mode = 0;
        check("fwd_emitted", 32'(cap_n - c0), 32'd3);
        check("fwd_last_index", 32'(cap_idx[c0 + 2]), 32'd2);
        check("fwd_mismatches", 32'(fwd_bad), 32'd0);
        check("fwd_sampled", 32'(fwd_n > 1000), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
